// File: rtl/lru_cache_ctrl.sv
// rtl/lru_cache_ctrl.sv - key/tag front end driving the LRU replacement queue handshake
module lru_cache_ctrl #(
  parameter int IDX_WIDTH  = 3,
  parameter int DATA_WIDTH = 8,
  parameter int KEY_WIDTH  = 16,
  parameter int CMD_WIDTH  = 2,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_op,
  input  logic [KEY_WIDTH-1:0]  req_key,
  input  logic [DATA_WIDTH-1:0] req_value,
  output logic                  resp_valid,
  output logic                  resp_hit,
  output logic [IDX_WIDTH-1:0]  resp_idx,
  output logic [DATA_WIDTH-1:0] resp_value,
  output logic                  resp_evict_valid,
  output logic [KEY_WIDTH-1:0]  resp_evict_key,
  output logic [DATA_WIDTH-1:0] resp_evict_value,
  output logic                  error,
  output logic [CMD_WIDTH:0]    q_command,
  output logic                  q_enable,
  input  logic                  q_ready,
  input  logic                  q_crashed,
  output logic [IDX_WIDTH-1:0]  q_idx,
  output logic [DATA_WIDTH-1:0] q_data,
  input  logic [IDX_WIDTH-1:0]  q_idx_out,
  input  logic [DATA_WIDTH-1:0] q_data_out
);
  localparam int NSLOTS = 1 << IDX_WIDTH;
  localparam int WD_W   = $clog2(TIMEOUT + 2);
  localparam logic [CMD_WIDTH:0] CMD_NOP    = (CMD_WIDTH+1)'(0);
  localparam logic [CMD_WIDTH:0] CMD_ENLIST = (CMD_WIDTH+1)'(1);
  localparam logic [CMD_WIDTH:0] CMD_BACK   = (CMD_WIDTH+1)'(2);
  localparam logic [CMD_WIDTH:0] CMD_READ   = (CMD_WIDTH+1)'(3);

  typedef enum logic [2:0] {IDLE, MATCH, Q_ISSUE, Q_WAIT, Q_RELEASE, RESPOND, ERR} state_t;
  state_t state, state_nxt;

  logic                  op_r;
  logic [KEY_WIDTH-1:0]  key_r;
  logic [DATA_WIDTH-1:0] value_r;
  logic [KEY_WIDTH-1:0]  tag [NSLOTS];
  logic [NSLOTS-1:0]     valid;
  logic [CMD_WIDTH:0]    cmd_r;
  logic                  hit_r;
  logic [IDX_WIDTH-1:0]  hit_idx_r;
  logic [DATA_WIDTH-1:0] hit_val_r;
  logic                  ev_valid_r;
  logic [KEY_WIDTH-1:0]  ev_key_r;
  logic [DATA_WIDTH-1:0] ev_val_r;
  logic [WD_W-1:0]       wd_cnt;
  logic                  match_found;
  logic [IDX_WIDTH-1:0]  match_idx;
  logic                  wd_expired;

  // Scan downwards so the lowest matching slot is the one left standing.
  always_comb begin
    match_found = 1'b0;
    match_idx   = '0;
    for (int i = NSLOTS - 1; i >= 0; i--) begin
      if (valid[i] && tag[i] == key_r) begin
        match_found = 1'b1;
        match_idx   = IDX_WIDTH'(i);
      end
    end
  end

  assign wd_expired = (wd_cnt == WD_W'(TIMEOUT));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (req_valid) state_nxt = MATCH;
      MATCH:     state_nxt = (!match_found && !op_r) ? RESPOND : Q_ISSUE;
      Q_ISSUE:   state_nxt = Q_WAIT;
      Q_WAIT:    if (q_ready) state_nxt = Q_RELEASE;
                 else if (wd_expired) state_nxt = ERR;
      Q_RELEASE: if (!q_ready) state_nxt = (cmd_r == CMD_READ) ? Q_ISSUE : RESPOND;
                 else if (wd_expired) state_nxt = ERR;
      RESPOND:   state_nxt = IDLE;
      ERR:       state_nxt = ERR;
      default:   state_nxt = ERR;
    endcase
    if (q_crashed) state_nxt = ERR;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESPOND);
  assign error      = (state == ERR);
  assign q_enable   = (state == Q_ISSUE) || (state == Q_WAIT);
  assign q_command  = q_enable ? cmd_r : CMD_NOP;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_r <= 1'b0; key_r <= '0; value_r <= '0; valid <= '0; cmd_r <= CMD_NOP;
      for (int i = 0; i < NSLOTS; i++) tag[i] <= '0;
      hit_r <= 1'b0; hit_idx_r <= '0; hit_val_r <= '0;
      ev_valid_r <= 1'b0; ev_key_r <= '0; ev_val_r <= '0;
      q_idx <= '0; q_data <= '0; wd_cnt <= '0;
      resp_hit <= 1'b0; resp_idx <= '0; resp_value <= '0;
      resp_evict_valid <= 1'b0; resp_evict_key <= '0; resp_evict_value <= '0;
    end else begin
      if ((state_nxt == Q_WAIT && state != Q_WAIT) || (state_nxt == Q_RELEASE && state != Q_RELEASE))
        wd_cnt <= '0;
      else if (state == Q_WAIT || state == Q_RELEASE)
        wd_cnt <= wd_cnt + 1'b1;

      case (state)
        IDLE: if (req_valid) begin
          op_r <= req_op; key_r <= req_key; value_r <= req_value;
        end
        MATCH: begin
          hit_r <= match_found; hit_idx_r <= match_found ? match_idx : '0; hit_val_r <= '0;
          ev_valid_r <= 1'b0; ev_key_r <= '0; ev_val_r <= '0;
          if (match_found) begin
            cmd_r <= CMD_READ; q_idx <= match_idx; q_data <= '0;
          end else if (op_r) begin
            cmd_r <= CMD_ENLIST; q_idx <= '0; q_data <= value_r;
          end else begin
            resp_hit <= 1'b0; resp_idx <= '0; resp_value <= '0;
            resp_evict_valid <= 1'b0; resp_evict_key <= '0; resp_evict_value <= '0;
          end
        end
        Q_WAIT: if (q_ready) begin
          if (cmd_r == CMD_READ) hit_val_r <= q_data_out;
          if (cmd_r == CMD_ENLIST) begin
            hit_idx_r       <= q_idx_out;
            ev_valid_r      <= valid[q_idx_out];
            ev_key_r        <= tag[q_idx_out];
            ev_val_r        <= q_data_out;
            tag[q_idx_out]  <= key_r;
            valid[q_idx_out] <= 1'b1;
          end
        end
        // After READDATA completes the same slot is sent to the back of the queue.
        Q_RELEASE: if (!q_ready) begin
          if (cmd_r == CMD_READ) cmd_r <= CMD_BACK;
          else begin
            resp_hit <= hit_r; resp_idx <= hit_idx_r; resp_value <= hit_val_r;
            resp_evict_valid <= ev_valid_r; resp_evict_key <= ev_key_r; resp_evict_value <= ev_val_r;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_lru_cache_ctrl.sv
// tb/tb_lru_cache_ctrl.sv - directed bench with an LRU queue responder and a reference LRU model
module tb_lru_cache_ctrl;
  localparam int IW = 2, DW = 8, KW = 16, CW = 2, TO = 15, N = 4;

  logic clock = 1'b0;
  logic reset;
  logic req_valid, req_ready, req_op;
  logic [KW-1:0] req_key;
  logic [DW-1:0] req_value;
  logic resp_valid, resp_hit, resp_evict_valid, error;
  logic [IW-1:0] resp_idx;
  logic [DW-1:0] resp_value, resp_evict_value;
  logic [KW-1:0] resp_evict_key;
  logic [CW:0] q_command;
  logic q_enable, q_ready, q_crashed;
  logic [IW-1:0] q_idx, q_idx_out;
  logic [DW-1:0] q_data, q_data_out;

  always #5 clock = ~clock;

  lru_cache_ctrl #(.IDX_WIDTH(IW), .DATA_WIDTH(DW), .KEY_WIDTH(KW), .CMD_WIDTH(CW), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_key(req_key), .req_value(req_value), .resp_valid(resp_valid), .resp_hit(resp_hit),
    .resp_idx(resp_idx), .resp_value(resp_value), .resp_evict_valid(resp_evict_valid),
    .resp_evict_key(resp_evict_key), .resp_evict_value(resp_evict_value), .error(error),
    .q_command(q_command), .q_enable(q_enable), .q_ready(q_ready), .q_crashed(q_crashed),
    .q_idx(q_idx), .q_data(q_data), .q_idx_out(q_idx_out), .q_data_out(q_data_out));

  int checks = 0, passes = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Queue responder: ready follows enable one cycle later; commands act on a slot recency list.
  int qorder[$];
  logic [DW-1:0] qdata [N];
  bit q_stall = 0;
  typedef struct { int cmd; int idx; } logent_t;
  logent_t qlog[$];

  task automatic q_reset();
    qorder = {};
    for (int i = N - 1; i >= 0; i--) qorder.push_back(i);
    for (int i = 0; i < N; i++) qdata[i] = '0;
    q_ready = 1'b0; q_idx_out = '0; q_data_out = '0;
  endtask

  initial begin : queue_env
    logic en;
    logic [CW:0] cmd;
    logic [IW-1:0] qi;
    logic [DW-1:0] qd;
    int s;
    q_reset();
    forever begin
      @(negedge clock);
      en = q_enable; cmd = q_command; qi = q_idx; qd = q_data;
      @(posedge clock); #1;
      if (reset) q_reset();
      else if (en && !q_ready && !q_stall) begin
        case (cmd)
          3'd1: begin
            s = qorder.pop_front();
            q_idx_out = IW'(s); q_data_out = qdata[s]; qdata[s] = qd; qorder.push_back(s);
          end
          3'd2: begin
            for (int j = 0; j < qorder.size(); j++)
              if (qorder[j] == int'(qi)) begin qorder.delete(j); break; end
            qorder.push_back(int'(qi));
            q_idx_out = qi; q_data_out = qdata[qi];
          end
          default: begin q_idx_out = qi; q_data_out = qdata[qi]; end
        endcase
        qlog.push_back('{int'(cmd), int'(qi)});
        q_ready = 1'b1;
      end else if (!en) q_ready = 1'b0;
    end
  end

  // Reference model: recency-ordered entries, slots handed out top-down until full.
  typedef struct { logic [KW-1:0] key; logic [DW-1:0] val; int slot; } ent_t;
  ent_t lru[$];
  int next_free = N - 1;
  bit pending = 0, hang_req = 0, saw_en = 0;
  int ncyc = 0, acc = 0;
  int e_lat, e_idx;
  bit e_hit, e_ev, e_chk_val;
  logic [DW-1:0] e_val, e_evv;
  logic [KW-1:0] e_evk;

  task automatic model_req(input bit op, input logic [KW-1:0] k, input logic [DW-1:0] v);
    int pos = -1;
    ent_t e;
    for (int j = 0; j < lru.size(); j++) if (lru[j].key == k) pos = j;
    e_ev = 0; e_evk = '0; e_evv = '0; e_chk_val = 1;
    if (pos >= 0) begin
      e = lru[pos]; lru.delete(pos); lru.push_back(e);
      e_hit = 1; e_idx = e.slot; e_val = e.val; e_lat = 10;
    end else if (!op) begin
      e_hit = 0; e_idx = 0; e_val = '0; e_lat = 2;
    end else begin
      e_hit = 0; e_lat = 6; e_chk_val = 0; e_val = '0;
      if (lru.size() < N) begin e_idx = next_free; next_free--; end
      else begin
        e = lru.pop_front();
        e_idx = e.slot; e_ev = 1; e_evk = e.key; e_evv = e.val;
      end
      lru.push_back('{k, v, e_idx});
    end
  endtask

  initial begin : compare
    forever begin
      @(negedge clock);
      ncyc++;
      if (reset) begin
        lru = {}; next_free = N - 1; pending = 0;
      end else begin
        if (pending && q_enable) saw_en = 1;
        if (resp_valid) begin
          if (!pending) check("resp_spurious", 32'(resp_valid), 0);
          else begin
            check("resp_latency", ncyc - acc, e_lat);
            check("resp_hit", 32'(resp_hit), 32'(e_hit));
            check("resp_idx", 32'(resp_idx), e_idx);
            if (e_chk_val) check("resp_value", 32'(resp_value), 32'(e_val));
            check("resp_evict_valid", 32'(resp_evict_valid), 32'(e_ev));
            if (e_ev) begin
              check("resp_evict_key", 32'(resp_evict_key), 32'(e_evk));
              check("resp_evict_value", 32'(resp_evict_value), 32'(e_evv));
            end
            if (e_lat == 2) check("miss_no_queue", 32'(saw_en), 0);
            pending = 0;
          end
        end else if (pending && ncyc - acc > e_lat) begin
          check("resp_timeout", 0, 1);
          pending = 0;
        end
        if (req_valid && req_ready && !hang_req) begin
          model_req(req_op, req_key, req_value);
          pending = 1; acc = ncyc; saw_en = 0;
        end
      end
    end
  end

  task automatic do_req(input bit op, input logic [KW-1:0] k, input logic [DW-1:0] v, input bit hang);
    hang_req = hang;
    req_valid = 1'b1; req_op = op; req_key = k; req_value = v;
    @(negedge clock);
    if (!req_ready) check("req_ready_idle", 32'(req_ready), 1);
    @(posedge clock); #1;
    req_valid = 1'b0; req_key = 16'hFFFF; req_value = 8'hEE; req_op = ~op;
    if (!hang) begin
      for (int i = 0; i < 40 && pending; i++) @(negedge clock);
      @(posedge clock); #1;
    end
    hang_req = 0;
  endtask

  task automatic wait_enable();
    int k = 0;
    while (!q_enable && k < 20) begin @(negedge clock); k++; end
    if (!q_enable) check("enable_rise", 32'(q_enable), 1);
  endtask

  task automatic check_reset_state();
    check("rst_req_ready", 32'(req_ready), 1);
    check("rst_resp_valid", 32'(resp_valid), 0);
    check("rst_q_enable", 32'(q_enable), 0);
    check("rst_q_command", 32'(q_command), 0);
    check("rst_error", 32'(error), 0);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_op = 1'b0; req_key = '0; req_value = '0; q_crashed = 1'b0;
    repeat (2) @(posedge clock); #1;
    check_reset_state();
    check("rst_resp_idx", 32'(resp_idx), 0);
    check("rst_evict_valid", 32'(resp_evict_valid), 0);
    reset = 1'b0;
    @(posedge clock); #1;

    for (int i = 0; i < 4; i++) begin
      do_req(1'b1, KW'(16'hA1 + i), DW'(8'h11 + i), 0);
      check("pin_fill_idx", 32'(resp_idx), 3 - i);
      check("pin_fill_evict", 32'(resp_evict_valid), 0);
    end
    do_req(1'b1, 16'hA5, 8'h15, 0);
    check("pin_a5_idx", 32'(resp_idx), 3);
    check("pin_a5_evk", 32'(resp_evict_key), 32'h00A1);
    check("pin_a5_evv", 32'(resp_evict_value), 32'h11);

    qlog = {};
    do_req(1'b0, 16'hA3, 8'h00, 0);
    check("pin_a3_hit", 32'(resp_hit), 1);
    check("pin_a3_idx", 32'(resp_idx), 1);
    check("pin_a3_val", 32'(resp_value), 32'h13);
    check("hit_cmd_count", qlog.size(), 2);
    if (qlog.size() == 2) begin
      check("hit_cmd0", qlog[0].cmd, 3);
      check("hit_cmd0_idx", qlog[0].idx, 1);
      check("hit_cmd1", qlog[1].cmd, 2);
      check("hit_cmd1_idx", qlog[1].idx, 1);
    end

    do_req(1'b1, 16'hA6, 8'h16, 0);
    check("pin_a6_idx", 32'(resp_idx), 2);
    check("pin_a6_evk", 32'(resp_evict_key), 32'h00A2);
    check("pin_a6_evv", 32'(resp_evict_value), 32'h12);
    qlog = {};
    do_req(1'b0, 16'hA1, 8'h00, 0);
    check("pin_a1_miss", 32'(resp_hit), 0);
    check("miss_cmd_count", qlog.size(), 0);

    do_req(1'b1, 16'hA5, 8'h99, 0);
    check("pin_ins_hit_val", 32'(resp_value), 32'h15);
    do_req(1'b0, 16'hA5, 8'h00, 0);
    check("pin_a5_unchanged", 32'(resp_value), 32'h15);

    q_stall = 1;
    do_req(1'b1, 16'hA7, 8'h17, 1);
    wait_enable();
    for (int m = 1; m <= TO + 1; m++) @(negedge clock);
    check("wd_not_yet", 32'(error), 0);
    @(negedge clock);
    check("wd_error", 32'(error), 1);
    check("wd_req_ready", 32'(req_ready), 0);
    check("wd_q_enable", 32'(q_enable), 0);
    repeat (5) @(negedge clock);
    check("wd_sticky", 32'(error), 1);

    @(posedge clock); #1;
    reset = 1'b1; q_stall = 0;
    repeat (2) @(posedge clock); #1;
    check_reset_state();
    reset = 1'b0;
    @(posedge clock); #1;
    do_req(1'b0, 16'hA5, 8'h00, 0);
    check("pin_post_err_miss", 32'(resp_hit), 0);

    q_stall = 1;
    do_req(1'b1, 16'hA8, 8'h18, 1);
    wait_enable();
    @(negedge clock);
    check("midrst_in_wait", 32'(q_enable), 1);
    reset = 1'b1;
    #1;
    check("midrst_q_enable", 32'(q_enable), 0);
    check("midrst_resp_valid", 32'(resp_valid), 0);
    q_stall = 0;
    repeat (2) @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    do_req(1'b1, 16'hB1, 8'h21, 0);
    check("pin_b1_idx", 32'(resp_idx), 3);
    check("pin_b1_evict", 32'(resp_evict_valid), 0);

    repeat (2) @(posedge clock);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
